// File: rtl/tinychip_pkg.sv
// Shared types for the tinychip fetch path: address/instruction widths,
// fetch FSM state encoding and the buffered fetch entry (pc + instruction).
// Imported by instr_fetch and fetch_fifo.
package tinychip_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: small circular buffer of fetch entries with push/pop/flush.
// Latency: push visible at the head one cycle later (no bypass).
// Backpressure: push is dropped when full unless a pop happens in the same
// cycle; flush empties the buffer and overrides push/pop.
// Ports: clk, reset (async, active low), push/push_dat, pop, flush,
//        head_dat (entry at read pointer), count, full, empty.
module fetch_fifo
  import tinychip_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_dat,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head_dat,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: drives the PC to instruction memory, qualifies each fetched
// word against the memory's registered end-of-program flag one cycle later,
// buffers good words and hands them to the decoder over valid/ready.
// Latency: fetch to instr_valid is 2 cycles; one fetch per cycle when the
// decoder keeps up. Backpressure: with the buffer full and instr_ready low,
// pc, imem_addr and the staged word hold.
// Ports: clk, reset (async, active low), start, imem_addr/imem_instr/
//        imem_done (memory side), branch_valid/branch_target (redirect),
//        instr_out/instr_pc/instr_valid/instr_ready (decoder), halted.
// Build option IFETCH_WRAP_HALT_EN: the fetch at the top address is the last
// one and the block drains instead of wrapping the pc to 0.
module instr_fetch
  import tinychip_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               imem_done,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state;
  addr_t            pc;
  fetch_entry_t     stage;
  logic             stage_valid;
  // Stage already passed its imem_done check but is waiting for buffer room;
  // imem_done then describes the held pc, not the staged word.
  logic             stage_qual;
  // Wrap-halt build: the top address has been fetched, no further issue.
  logic             fetch_end;

  logic             active;
  logic             take_branch;
  logic             take_start;
  logic             stage_ok;
  logic             stage_discard;
  logic             issue;
  logic             last_issue;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;

  assign active      = (state == RUN) || (state == DRAIN);
  assign take_branch = active && branch_valid;
  assign take_start  = ((state == IDLE) || (state == HALT)) && start;

  assign fifo_pop      = instr_valid && instr_ready;
  assign stage_ok      = stage_valid && (stage_qual || !imem_done);
  assign stage_discard = stage_valid && !stage_qual && imem_done;
  // Branch wins over any push in the same cycle.
  assign fifo_push     = stage_ok && (!fifo_full || fifo_pop) && !take_branch;
  assign fifo_flush    = take_branch || take_start;

  // Issue only when the stage will be free at the end of this cycle.
  assign issue = (state == RUN) && !take_branch && !fetch_end &&
                 !stage_discard && (!stage_valid || fifo_push);

`ifdef IFETCH_WRAP_HALT_EN
  assign last_issue = issue && (&pc);
`else
  assign last_issue = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      stage       <= '0;
      stage_valid <= 1'b0;
      stage_qual  <= 1'b0;
      fetch_end   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RUN;
            pc          <= '0;
            stage_valid <= 1'b0;
            stage_qual  <= 1'b0;
            fetch_end   <= 1'b0;
            halted      <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (branch_valid) begin
            state       <= RUN;
            pc          <= branch_target;
            stage_valid <= 1'b0;
            stage_qual  <= 1'b0;
            fetch_end   <= 1'b0;
          end else begin
            if (issue) begin
              stage.pc    <= pc;
              stage.instr <= imem_instr;
              stage_valid <= 1'b1;
              stage_qual  <= 1'b0;
              if (last_issue) begin
                fetch_end <= 1'b1;
              end else begin
                pc <= pc + 1'b1;
              end
            end else if (stage_valid) begin
              if (stage_discard || fifo_push) begin
                stage_valid <= 1'b0;
              end else begin
                stage_qual <= 1'b1;
              end
            end

            if (state == RUN) begin
              if (stage_discard || (fetch_end && fifo_push)) begin
                state <= DRAIN;
              end
            end else if ((fifo_count == '0) && !stage_valid) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign imem_addr = pc;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (stage),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_out   = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

endmodule
